// File: rtl/register_block_seq.sv
// Z80 LDI/LDD/LDIR/LDDR sequencer: drives register-file strobes, ALU op and memory handshake.
// Optional macro REGISTER_BLOCK_SEQ_REFRESH_EN adds the PR_Inc_R refresh-increment output.
//
// state  | meaning
// IDLE   | waiting for Start
// RD     | read (HL), wait for MemAck
// WR     | write (DE), wait for MemAck
// UHL    | HL +/- 1
// UDE    | DE +/- 1
// UBC    | BC - 1, iteration counter - 1
// CHK    | write H/N/PV flags, decide loop / rewind / finish
// REW    | PC - 2 so the interrupted LDxR is refetched
// DONE   | one-cycle completion pulse
module register_block_seq #(
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Repeat,
   input  logic             Decrement,
   input  logic [CNT_W-1:0] BC,
   input  logic             IntReq,
   input  logic             MemAck,
   output logic             MemRd,
   output logic             MemWr,
   output logic [1:0]       AddrSel,
   output logic             PI_ReadDtcs,
   output logic [2:0]       AluOp,
   output logic             PR_Write_H,
   output logic             PR_Write_L,
   output logic             PR_Write_D,
   output logic             PR_Write_E,
   output logic             PR_Write_B,
   output logic             PR_Write_C,
   output logic             PR_Write_PC_high,
   output logic             PR_Write_PC_low,
   output logic             PF_Write_H,
   output logic             PF_Write_N,
   output logic             PF_Write_PV,
   output logic             FlagPV,
   output logic             Busy,
   output logic             Done,
   output logic             Error
`ifdef REGISTER_BLOCK_SEQ_REFRESH_EN
   ,
   output logic             PR_Inc_R
`endif
);

   localparam int WAIT_W = (MAX_WAIT < 15) ? 4 : $clog2(MAX_WAIT + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_RD, S_WR, S_UHL, S_UDE, S_UBC, S_CHK, S_REW, S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic               rep_q, rep_d;
   logic               dec_q, dec_d;

   logic               mem_rd_q, mem_rd_d;
   logic               mem_wr_q, mem_wr_d;
   logic [1:0]         addr_sel_q, addr_sel_d;
   logic [2:0]         alu_op_q, alu_op_d;
   logic               wr_h_q, wr_h_d, wr_l_q, wr_l_d;
   logic               wr_d_q, wr_d_d, wr_e_q, wr_e_d;
   logic               wr_b_q, wr_b_d, wr_c_q, wr_c_d;
   logic               wr_pch_q, wr_pch_d, wr_pcl_q, wr_pcl_d;
   logic               pf_wr_q, pf_wr_d;
   logic               flag_pv_q, flag_pv_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               inc_r_q, inc_r_d;

   // next-state, counters and latched op mode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wait_d  = wait_q;
      rep_d   = rep_q;
      dec_d   = dec_q;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               state_d = S_RD;
               cnt_d   = BC;
               rep_d   = Repeat;
               dec_d   = Decrement;
               wait_d  = '0;
            end
         end
         S_RD, S_WR: begin
            if (MemAck) begin
               state_d = (state_q == S_RD) ? S_WR : S_UHL;
               wait_d  = '0;
            end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
               state_d = S_DONE;
               err_d   = 1'b1;
               wait_d  = '0;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_UHL: state_d = S_UDE;
         S_UDE: state_d = S_UBC;
         S_UBC: begin
            state_d = S_CHK;
            cnt_d   = cnt_q - CNT_W'(1);
         end
         S_CHK: begin
            if (rep_q && (cnt_q != '0)) begin
               state_d = IntReq ? S_REW : S_RD;
               wait_d  = '0;
            end else begin
               state_d = S_DONE;
            end
         end
         S_REW:   state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // outputs decoded from the next state so they are registered and glitch-free
   always_comb begin
      mem_rd_d   = 1'b0;
      mem_wr_d   = 1'b0;
      addr_sel_d = 2'b00;
      alu_op_d   = 3'd0;
      wr_h_d     = 1'b0;
      wr_l_d     = 1'b0;
      wr_d_d     = 1'b0;
      wr_e_d     = 1'b0;
      wr_b_d     = 1'b0;
      wr_c_d     = 1'b0;
      wr_pch_d   = 1'b0;
      wr_pcl_d   = 1'b0;
      pf_wr_d    = 1'b0;
      flag_pv_d  = 1'b0;
      inc_r_d    = 1'b0;
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
      case (state_d)
         S_RD: begin
            mem_rd_d   = 1'b1;
            addr_sel_d = 2'b01;
         end
         S_WR: begin
            mem_wr_d   = 1'b1;
            addr_sel_d = 2'b10;
         end
         S_UHL: begin
            alu_op_d = dec_d ? 3'd2 : 3'd1;
            wr_h_d   = 1'b1;
            wr_l_d   = 1'b1;
         end
         S_UDE: begin
            alu_op_d = dec_d ? 3'd2 : 3'd1;
            wr_d_d   = 1'b1;
            wr_e_d   = 1'b1;
         end
         S_UBC: begin
            alu_op_d = 3'd2;
            wr_b_d   = 1'b1;
            wr_c_d   = 1'b1;
         end
         S_CHK: begin
            pf_wr_d   = 1'b1;
            flag_pv_d = (cnt_d != '0);
            inc_r_d   = rep_d && (cnt_d != '0);
         end
         S_REW: begin
            alu_op_d = 3'd3;
            wr_pch_d = 1'b1;
            wr_pcl_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         wait_q     <= '0;
         rep_q      <= 1'b0;
         dec_q      <= 1'b0;
         mem_rd_q   <= 1'b0;
         mem_wr_q   <= 1'b0;
         addr_sel_q <= 2'b00;
         alu_op_q   <= 3'd0;
         wr_h_q     <= 1'b0;
         wr_l_q     <= 1'b0;
         wr_d_q     <= 1'b0;
         wr_e_q     <= 1'b0;
         wr_b_q     <= 1'b0;
         wr_c_q     <= 1'b0;
         wr_pch_q   <= 1'b0;
         wr_pcl_q   <= 1'b0;
         pf_wr_q    <= 1'b0;
         flag_pv_q  <= 1'b0;
         inc_r_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wait_q     <= wait_d;
         rep_q      <= rep_d;
         dec_q      <= dec_d;
         mem_rd_q   <= mem_rd_d;
         mem_wr_q   <= mem_wr_d;
         addr_sel_q <= addr_sel_d;
         alu_op_q   <= alu_op_d;
         wr_h_q     <= wr_h_d;
         wr_l_q     <= wr_l_d;
         wr_d_q     <= wr_d_d;
         wr_e_q     <= wr_e_d;
         wr_b_q     <= wr_b_d;
         wr_c_q     <= wr_c_d;
         wr_pch_q   <= wr_pch_d;
         wr_pcl_q   <= wr_pcl_d;
         pf_wr_q    <= pf_wr_d;
         flag_pv_q  <= flag_pv_d;
         inc_r_q    <= inc_r_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign MemRd            = mem_rd_q;
   assign MemWr            = mem_wr_q;
   assign AddrSel          = addr_sel_q;
   assign AluOp            = alu_op_q;
   assign PR_Write_H       = wr_h_q;
   assign PR_Write_L       = wr_l_q;
   assign PR_Write_D       = wr_d_q;
   assign PR_Write_E       = wr_e_q;
   assign PR_Write_B       = wr_b_q;
   assign PR_Write_C       = wr_c_q;
   assign PR_Write_PC_high = wr_pch_q;
   assign PR_Write_PC_low  = wr_pcl_q;
   assign PF_Write_H       = pf_wr_q;
   assign PF_Write_N       = pf_wr_q;
   assign PF_Write_PV      = pf_wr_q;
   assign FlagPV           = flag_pv_q;
   assign Busy             = busy_q;
   assign Done             = done_q;
   assign Error            = err_q;

   // the data latch must fire in the same cycle MemAck arrives, so it cannot be registered
   assign PI_ReadDtcs = (state_q == S_RD) && MemAck;

`ifdef REGISTER_BLOCK_SEQ_REFRESH_EN
   assign PR_Inc_R = inc_r_q;
`else
   logic unused_inc_r;
   assign unused_inc_r = inc_r_q;
`endif

endmodule

// File: tb/tb_register_block_seq.sv
// Directed self-checking bench for register_block_seq: per-cycle output vectors per scenario.
module tb_register_block_seq;

   logic        Clk, Reset, Start, Repeat, Decrement, IntReq, MemAck;
   logic [15:0] BC;
   logic        MemRd, MemWr, PI_ReadDtcs, Busy, Done, Error, FlagPV;
   logic [1:0]  AddrSel;
   logic [2:0]  AluOp;
   logic        PR_Write_H, PR_Write_L, PR_Write_D, PR_Write_E, PR_Write_B, PR_Write_C;
   logic        PR_Write_PC_high, PR_Write_PC_low, PF_Write_H, PF_Write_N, PF_Write_PV;
`ifdef REGISTER_BLOCK_SEQ_REFRESH_EN
   logic        PR_Inc_R;
`endif

   int errors = 0;
   int checks = 0;

   register_block_seq #(.MAX_WAIT(15), .CNT_W(16)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Repeat(Repeat), .Decrement(Decrement),
      .BC(BC), .IntReq(IntReq), .MemAck(MemAck), .MemRd(MemRd), .MemWr(MemWr),
      .AddrSel(AddrSel), .PI_ReadDtcs(PI_ReadDtcs), .AluOp(AluOp),
      .PR_Write_H(PR_Write_H), .PR_Write_L(PR_Write_L), .PR_Write_D(PR_Write_D),
      .PR_Write_E(PR_Write_E), .PR_Write_B(PR_Write_B), .PR_Write_C(PR_Write_C),
      .PR_Write_PC_high(PR_Write_PC_high), .PR_Write_PC_low(PR_Write_PC_low),
      .PF_Write_H(PF_Write_H), .PF_Write_N(PF_Write_N), .PF_Write_PV(PF_Write_PV),
      .FlagPV(FlagPV), .Busy(Busy), .Done(Done), .Error(Error)
`ifdef REGISTER_BLOCK_SEQ_REFRESH_EN
      , .PR_Inc_R(PR_Inc_R)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // {MemRd, MemWr, AddrSel, PI_ReadDtcs, AluOp, H,L,D,E,B,C,PCH,PCL, PFH,PFN,PFPV, FlagPV, Busy, Done, Error}
   logic [22:0] obs;
   assign obs = {MemRd, MemWr, AddrSel, PI_ReadDtcs, AluOp,
                 PR_Write_H, PR_Write_L, PR_Write_D, PR_Write_E,
                 PR_Write_B, PR_Write_C, PR_Write_PC_high, PR_Write_PC_low,
                 PF_Write_H, PF_Write_N, PF_Write_PV, FlagPV, Busy, Done, Error};

   localparam logic [22:0] E_IDLE     = '0;
   localparam logic [22:0] E_RD_ACK   = {1'b1, 1'b0, 2'b01, 1'b1, 3'd0, 8'b0000_0000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam logic [22:0] E_RD_WAIT  = {1'b1, 1'b0, 2'b01, 1'b0, 3'd0, 8'b0000_0000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam logic [22:0] E_WR       = {1'b0, 1'b1, 2'b10, 1'b0, 3'd0, 8'b0000_0000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam logic [22:0] E_UHL_I    = {1'b0, 1'b0, 2'b00, 1'b0, 3'd1, 8'b1100_0000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam logic [22:0] E_UHL_D    = {1'b0, 1'b0, 2'b00, 1'b0, 3'd2, 8'b1100_0000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam logic [22:0] E_UDE_I    = {1'b0, 1'b0, 2'b00, 1'b0, 3'd1, 8'b0011_0000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam logic [22:0] E_UDE_D    = {1'b0, 1'b0, 2'b00, 1'b0, 3'd2, 8'b0011_0000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam logic [22:0] E_UBC      = {1'b0, 1'b0, 2'b00, 1'b0, 3'd2, 8'b0000_1100, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam logic [22:0] E_CHK1     = {1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 8'b0000_0000, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0};
   localparam logic [22:0] E_CHK0     = {1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 8'b0000_0000, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam logic [22:0] E_REW      = {1'b0, 1'b0, 2'b00, 1'b0, 3'd3, 8'b0000_0011, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam logic [22:0] E_DONE     = {1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 8'b0000_0000, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0};
   localparam logic [22:0] E_DONE_ERR = {1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 8'b0000_0000, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1};

   // every task is entered and left 1 time unit after a rising edge
   task automatic test_reset();
      Reset = 1'b1;
      @(negedge Clk);
      checks++;
      if (obs !== E_IDLE) begin
         errors++;
         $display("FAIL reset_held: got %h expected %h", obs, E_IDLE);
      end
      @(posedge Clk); #1;
      Reset = 1'b0;
      @(negedge Clk);
      checks++;
      if (obs !== E_IDLE) begin
         errors++;
         $display("FAIL reset_release: got %h expected %h", obs, E_IDLE);
      end
      @(posedge Clk); #1;
   endtask

   task automatic test_ldi();
      logic [22:0] exp [8];
      int done_at;
      exp = '{E_RD_ACK, E_WR, E_UHL_I, E_UDE_I, E_UBC, E_CHK1, E_DONE, E_IDLE};
      done_at = -1;
      MemAck = 1'b1; Repeat = 1'b0; Decrement = 1'b0; IntReq = 1'b0; BC = 16'h0003;
      Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge Clk);
         checks++;
         if (obs !== exp[i]) begin
            errors++;
            $display("FAIL ldi_seq[%0d]: got %h expected %h", i, obs, exp[i]);
         end
         if (Done && done_at < 0) done_at = i;
         @(posedge Clk); #1;
      end
      checks++;
      if (done_at + 2 != 8) begin
         errors++;
         $display("FAIL ldi_latency: got %0d cycles expected 8", done_at + 2);
      end
   endtask

   task automatic test_ldir();
      logic [22:0] exp [14];
      int done_at, n_done;
      exp = '{E_RD_ACK, E_WR, E_UHL_I, E_UDE_I, E_UBC, E_CHK1,
              E_RD_ACK, E_WR, E_UHL_I, E_UDE_I, E_UBC, E_CHK0, E_DONE, E_IDLE};
      done_at = -1; n_done = 0;
      MemAck = 1'b1; Repeat = 1'b1; Decrement = 1'b0; IntReq = 1'b0; BC = 16'h0002;
      Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      for (int i = 0; i < 14; i++) begin
         @(negedge Clk);
         checks++;
         if (obs !== exp[i]) begin
            errors++;
            $display("FAIL ldir_seq[%0d]: got %h expected %h", i, obs, exp[i]);
         end
         if (Done) begin
            n_done++;
            if (done_at < 0) done_at = i;
         end
         @(posedge Clk); #1;
      end
      checks++;
      if (done_at + 2 != 14 || n_done != 1) begin
         errors++;
         $display("FAIL ldir_latency: got %0d cycles / %0d Done pulses expected 14 / 1",
                  done_at + 2, n_done);
      end
   endtask

   task automatic test_lddr_int();
      logic [22:0] exp [15];
      exp = '{E_RD_ACK, E_WR, E_UHL_D, E_UDE_D, E_UBC, E_CHK1,
              E_RD_ACK, E_WR, E_UHL_D, E_UDE_D, E_UBC, E_CHK1, E_REW, E_DONE, E_IDLE};
      MemAck = 1'b1; Repeat = 1'b1; Decrement = 1'b1; IntReq = 1'b0; BC = 16'h0005;
      Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      for (int i = 0; i < 15; i++) begin
         IntReq = (i >= 11);
         @(negedge Clk);
         checks++;
         if (obs !== exp[i]) begin
            errors++;
            $display("FAIL lddr_int_seq[%0d]: got %h expected %h", i, obs, exp[i]);
         end
         @(posedge Clk); #1;
      end
      IntReq = 1'b0;
   endtask

   task automatic test_timeout();
      logic [22:0] expv;
      MemAck = 1'b0; Repeat = 1'b0; Decrement = 1'b0; IntReq = 1'b0; BC = 16'h0001;
      Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      for (int i = 0; i < 17; i++) begin
         expv = (i < 15) ? E_RD_WAIT : ((i == 15) ? E_DONE_ERR : E_IDLE);
         @(negedge Clk);
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL timeout_seq[%0d]: got %h expected %h", i, obs, expv);
         end
         @(posedge Clk); #1;
      end
      MemAck = 1'b1;
   endtask

   task automatic test_wrap_busy_start();
      logic [22:0] exp [10];
      exp = '{E_RD_ACK, E_WR, E_UHL_I, E_UDE_I, E_UBC, E_CHK1, E_REW, E_DONE, E_IDLE, E_IDLE};
      MemAck = 1'b1; Repeat = 1'b1; Decrement = 1'b0; IntReq = 1'b0; BC = 16'h0000;
      Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         Start  = (i == 2 || i == 7);
         IntReq = (i == 5);
         @(negedge Clk);
         checks++;
         if (obs !== exp[i]) begin
            errors++;
            $display("FAIL wrap_seq[%0d]: got %h expected %h", i, obs, exp[i]);
         end
         @(posedge Clk); #1;
      end
      Start = 1'b0; IntReq = 1'b0;
   endtask

   task automatic test_reset_mid();
      MemAck = 1'b1; Repeat = 1'b1; Decrement = 1'b0; IntReq = 1'b0; BC = 16'h0004;
      Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      repeat (3) begin
         @(posedge Clk); #1;
      end
      @(negedge Clk);
      checks++;
      if (obs !== E_UDE_I) begin
         errors++;
         $display("FAIL mid_pre_reset: got %h expected %h", obs, E_UDE_I);
      end
      #2 Reset = 1'b1;
      #1;
      checks++;
      if (obs !== E_IDLE) begin
         errors++;
         $display("FAIL mid_async_reset: got %h expected %h", obs, E_IDLE);
      end
      @(posedge Clk); #1;
      Reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         checks++;
         if (obs !== E_IDLE) begin
            errors++;
            $display("FAIL mid_after_reset[%0d]: got %h expected %h", i, obs, E_IDLE);
         end
         @(posedge Clk); #1;
      end
      test_ldi();
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; Repeat = 1'b0; Decrement = 1'b0;
      IntReq = 1'b0; MemAck = 1'b0; BC = '0;
      @(posedge Clk); #1;
      test_reset();
      test_ldi();
      test_ldir();
      test_lddr_int();
      test_timeout();
      test_wrap_busy_start();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/register_block_seq.md
Name: register_block_seq

Overview:
- Sequencer for Z80 block-transfer instructions LDI/LDD/LDIR/LDDR.
- Drives the register-file write strobes, ALU op select and memory handshake to:
  - move one byte from (HL) to (DE);
  - step HL and DE up or down;
  - decrement BC;
  - update flags;
  - on an interrupt during a repeat, rewind PC by 2.
- Sits between instruction decode and the register block. Owns the shared ALU and register write port while Busy.

Parameters:
- MAX_WAIT, 15, max cycles to wait for MemAck in a memory state before aborting with Error (counter width 4 bits minimum).
- CNT_W, 16, width of the internal iteration counter (matches BC).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle request to begin a block op; ignored while Busy.
- Repeat  in  1  sampled at Start. 1 = LDIR/LDDR, 0 = LDI/LDD.
- Decrement  in  1  sampled at Start. 1 = HL/DE step down, 0 = step up.
- BC  in  CNT_W  true-polarity BC, sampled at Start.
- IntReq  in  1  pending maskable/NMI interrupt, sampled in CHK.
- MemAck  in  1  memory cycle complete.
- MemRd  out  1  read request, address from HL.
- MemWr  out  1  write request, address from DE.
- AddrSel  out  2  00 none, 01 HL, 10 DE.
- PI_ReadDtcs  out  1  latch Din into Dtcs.
- AluOp  out  3  0 none, 1 INC16, 2 DEC16, 3 SUB2 (PC-2).
- PR_Write_H, PR_Write_L, PR_Write_D, PR_Write_E, PR_Write_B, PR_Write_C, PR_Write_PC_high, PR_Write_PC_low  out  1 each  register write strobes.
- PF_Write_H, PF_Write_N, PF_Write_PV  out  1 each  flag write strobes.
- FlagPV  out  1  PV value to write.
- Busy  out  1  sequencer owns datapath.
- Done  out  1  one-cycle completion pulse.
- Error  out  1  one-cycle pulse on MemAck timeout (coincident with Done).

Behaviour:
- Reset: state IDLE, counter 0, wait counter 0. Every output is 0 and stays 0 while Reset is high. Reset mid-operation abandons the op with no Done.
- States: IDLE, RD, WR, UHL, UDE, UBC, CHK, REW, DONE.
- IDLE: Start=1 loads cnt <= BC and latches Repeat/Decrement; next state RD. Busy=1 from RD through DONE inclusive.
- RD:
  - MemRd=1, AddrSel=01 until MemAck.
  - In the MemAck cycle PI_ReadDtcs=1; next state WR.
- WR: MemWr=1, AddrSel=10 until MemAck; next state UHL.
- Ack timeout: the wait counter clears on entry to RD/WR. If it reaches MAX_WAIT without MemAck, Error=1 and the next state is DONE.
- UHL: AluOp = Decrement ? 2 : 1; PR_Write_H=PR_Write_L=1. One cycle.
- UDE: as UHL, with PR_Write_D/E. One cycle.
- UBC:
  - AluOp=2; PR_Write_B=PR_Write_C=1.
  - cnt <= cnt-1, modulo 2^CNT_W. BC=0 at Start therefore gives 65536 iterations.
- CHK:
  - PF_Write_H=PF_Write_N=PF_Write_PV=1; FlagPV = (cnt != 0).
  - H and N are written 0 by the flag block.
  - Repeat=1 and cnt!=0 and IntReq=0: next state RD (internal loop, no refetch).
  - Repeat=1 and cnt!=0 and IntReq=1: next state REW.
  - Otherwise: next state DONE.
- REW: AluOp=3; PR_Write_PC_high=PR_Write_PC_low=1 (PC re-points at the ED prefix); next state DONE.
- DONE: Done=1 for one cycle; next state IDLE. Start in this cycle is ignored.
- Datapath exclusivity: at most one AluOp/write group is active per cycle. MemRd and MemWr are never both 1.
- Latency: a single LDI with zero-wait memory takes 8 cycles from Start to Done. Each additional LDIR iteration adds 6 cycles.

Optional Feature:
- Macro: REGISTER_BLOCK_SEQ_REFRESH_EN.
- Defined:
  - Extra output PR_Inc_R (1 bit).
  - PR_Inc_R pulses for 1 cycle in every CHK state where the loop continues to RD or REW, emulating the refetch refresh increments.
  - PR_Inc_R is 0 at reset.
- Undefined: the port is absent and R is untouched by the sequencer.

Test Plan:
- LDI, BC=0x0003, Decrement=0, MemAck tied 1 -> RD,WR,UHL(AluOp=1),UDE,UBC,CHK(FlagPV=1),DONE; Done 8 cycles after Start; Busy low afterwards.
- LDIR, BC=0x0002, zero wait -> two RD/WR pairs, CHK FlagPV=1 then 0, no REW, single Done pulse, total 14 cycles.
- LDDR, BC=0x0005, IntReq=1 from the 2nd CHK -> AluOp=2 in UHL/UDE, REW with AluOp=3 and PC strobes after the 2nd iteration, Done, FlagPV=1 in that CHK.
- LDI with MemAck held low in RD, MAX_WAIT=15 -> MemRd high 15 cycles, then Error=1 and Done=1 in the same cycle, no register strobes issued.
- LDIR, BC=0x0000 -> counter wraps to 0xFFFF, FlagPV=1 on the first CHK; Start pulsed while Busy is ignored.
- Reset asserted asynchronously during UDE -> all outputs 0 before the next Clk edge, no Done; a following Start runs normally.
